// File: rtl/reg_bank_encap.sv
// ARMv4 register bank wrapper: 16x32 GPRs with R15 as PC, IR-field index muxing,
// write-back muxing, PC sequencing and tri-state gating onto the B and C buses.
module reg_bank_encap #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LATCH_REG,
    input  logic [1:0]  IR_RD_MUX,
    input  logic        IR_RN_MUX,
    input  logic [1:0]  IR_RM_MUX,
    input  logic        RD_MUX,
    input  logic [1:0]  PC_MUX,
    input  logic        DATA_MUX,
    input  logic        REG_GATE_B,
    input  logic        REG_GATE_C,
    input  logic [31:0] IR,
    input  logic [31:0] ALU_BUS,
    input  logic [3:0]  REG_COUNTER,
    output logic [31:0] A_BUS,
    inout  wire  [31:0] B_BUS,
    output wire  [31:0] C_BUS,
    output logic [31:0] ST,
    output logic [31:0] PC
);

    logic [31:0] regs_r [16];
    logic [3:0]  rd_idx_s;
    logic [3:0]  rn_idx_s;
    logic [3:0]  rm_idx_s;
    logic [31:0] a_val_s;
    logic [31:0] b_val_s;
    logic [31:0] c_val_s;
    logic [31:0] wdata_s;
    logic [31:0] pc_next_s;
    logic        pc_overwrite_s;
    logic        unused_s;

    // R15 reads as the fetch address plus 4, i.e. the executing instruction + 8.
    function automatic logic [31:0] read_port(input logic [3:0] idx);
        if (idx == 4'd15) begin
            return regs_r[15] + 32'd4;
        end else begin
            return regs_r[idx];
        end
    endfunction

    // Register index selection from IR fields, LDM/STM counter or link register.
    always_comb begin
        rd_idx_s = IR[15:12];
        rm_idx_s = IR[3:0];
        case (IR_RD_MUX)
            2'd0:    rd_idx_s = IR[15:12];
            2'd1:    rd_idx_s = IR[19:16];
            2'd2:    rd_idx_s = REG_COUNTER;
            2'd3:    rd_idx_s = 4'd14;
            default: rd_idx_s = IR[15:12];
        endcase
        case (IR_RM_MUX)
            2'd0:    rm_idx_s = IR[3:0];
            2'd1:    rm_idx_s = IR[15:12];
            2'd2:    rm_idx_s = REG_COUNTER;
            2'd3:    rm_idx_s = IR[19:16];
            default: rm_idx_s = IR[3:0];
        endcase
        if (IR_RN_MUX) begin
            rn_idx_s = IR[15:12];
        end else begin
            rn_idx_s = IR[19:16];
        end
    end

    // Combinational read ports.
    always_comb begin
        a_val_s = read_port(rn_idx_s);
        b_val_s = read_port(rm_idx_s);
        c_val_s = read_port(IR[11:8]);
    end

    // Write-back data and next PC; a register write to R15 overrides PC sequencing.
    always_comb begin
        wdata_s   = ALU_BUS;
        pc_next_s = regs_r[15];
        if (RD_MUX) begin
            wdata_s = regs_r[15];
        end else if (DATA_MUX) begin
            wdata_s = B_BUS;
        end else begin
            wdata_s = ALU_BUS;
        end
        case (PC_MUX)
            2'd1:    pc_next_s = regs_r[15] + PC_STEP;
            2'd2:    pc_next_s = ALU_BUS;
            default: pc_next_s = regs_r[15];
        endcase
        pc_overwrite_s = LATCH_REG && (rd_idx_s == 4'd15);
    end

    // Register array update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 15; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
            regs_r[15] <= RESET_PC;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (LATCH_REG && (rd_idx_s == i[3:0])) begin
                    regs_r[i] <= wdata_s;
                end
            end
            if (pc_overwrite_s) begin
                regs_r[15] <= wdata_s;
            end else begin
                regs_r[15] <= pc_next_s;
            end
        end
    end

    // Shared buses are released while in reset even if their gate is high.
    assign B_BUS = (REG_GATE_B && rst) ? b_val_s : 32'bz;
    assign C_BUS = (REG_GATE_C && rst) ? c_val_s : 32'bz;

    assign A_BUS    = a_val_s;
    assign ST       = regs_r[13];
    assign PC       = regs_r[15];
    assign unused_s = ^{IR[31:20], IR[7:4]};

endmodule

// File: tb/tb_reg_bank_encap.sv
// Self-checking bench for reg_bank_encap: directed vector table, reset/load
// sequences, then randomized traffic against an array-based reference model.
module tb_reg_bank_encap;

    logic        clk = 1'b0;
    logic        rst;
    logic        latch;
    logic [1:0]  rd_sel;
    logic        rn_sel;
    logic [1:0]  rm_sel;
    logic        rd_mux;
    logic [1:0]  pc_mux;
    logic        data_mux;
    logic        gate_b;
    logic        gate_c;
    logic [31:0] ir;
    logic [31:0] alu;
    logic [3:0]  cnt;
    logic [31:0] a_bus;
    logic [31:0] st;
    logic [31:0] pc;
    logic        b_drv_en;
    logic [31:0] b_drv_val;
    tri1  [31:0] b_bus;
    tri1  [31:0] c_bus;

    int tests = 0;
    int fails = 0;

    assign b_bus = b_drv_en ? b_drv_val : 32'bz;

    always #5 clk = ~clk;

    reg_bank_encap dut (
        .clk(clk), .rst(rst), .LATCH_REG(latch), .IR_RD_MUX(rd_sel),
        .IR_RN_MUX(rn_sel), .IR_RM_MUX(rm_sel), .RD_MUX(rd_mux), .PC_MUX(pc_mux),
        .DATA_MUX(data_mux), .REG_GATE_B(gate_b), .REG_GATE_C(gate_c), .IR(ir),
        .ALU_BUS(alu), .REG_COUNTER(cnt), .A_BUS(a_bus), .B_BUS(b_bus),
        .C_BUS(c_bus), .ST(st), .PC(pc)
    );

    typedef struct {
        logic        latch;
        logic [1:0]  rd_sel;
        logic        rn_sel;
        logic [1:0]  rm_sel;
        logic        rd_mux;
        logic [1:0]  pc_mux;
        logic        data_mux;
        logic        gate_b;
        logic        gate_c;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [3:0]  cnt;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] exp_c;
        logic [31:0] exp_pc;
        logic [31:0] exp_st;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] m [16];
    logic [31:0] nm [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        latch = 1'b0; rd_sel = 2'd0; rn_sel = 1'b0; rm_sel = 2'd0; rd_mux = 1'b0;
        pc_mux = 2'd0; data_mux = 1'b0; gate_b = 1'b0; gate_c = 1'b0;
        ir = 32'h0; alu = 32'h0; cnt = 4'd0; b_drv_en = 1'b0; b_drv_val = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] idx);
        return (idx == 4'd15) ? m[15] + 32'd4 : m[idx];
    endfunction

    initial begin
        logic [31:0] r;
        logic [3:0]  dsel [4];
        logic [3:0]  bsel [4];
        logic [3:0]  d, a_idx;
        logic [31:0] e_b, wd;

        //               lat rd  rn rm  rdm pc  dm gb gc ir            alu           cnt   A             B             C             PC            ST
        tbl[0]  = '{1'b1,2'd0,1'b1,2'd1,1'b0,2'd0,1'b0,1'b1,1'b0,32'h0000_3000,32'hDEAD_BEEF,4'd0,32'hDEAD_BEEF,32'hDEAD_BEEF,32'hFFFF_FFFF,32'h0000_0000,32'h0};
        tbl[1]  = '{1'b0,2'd0,1'b0,2'd0,1'b0,2'd1,1'b0,1'b1,1'b1,32'h000F_0000,32'h0,        4'd0,32'h0000_0008,32'h0,        32'h0,        32'h0000_0004,32'h0};
        tbl[2]  = '{1'b0,2'd0,1'b0,2'd0,1'b0,2'd1,1'b0,1'b1,1'b1,32'h000F_0000,32'h0,        4'd0,32'h0000_000C,32'h0,        32'h0,        32'h0000_0008,32'h0};
        tbl[3]  = '{1'b0,2'd0,1'b0,2'd0,1'b0,2'd1,1'b0,1'b1,1'b1,32'h000F_0000,32'h0,        4'd0,32'h0000_0010,32'h0,        32'h0,        32'h0000_000C,32'h0};
        tbl[4]  = '{1'b1,2'd0,1'b1,2'd1,1'b0,2'd0,1'b0,1'b1,1'b1,32'h0000_2200,32'h5,        4'd0,32'h0000_0005,32'h5,        32'h5,        32'h0000_000C,32'h0};
        tbl[5]  = '{1'b0,2'd0,1'b1,2'd1,1'b0,2'd0,1'b0,1'b0,1'b0,32'h0000_2200,32'h5,        4'd0,32'h0000_0005,32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0000_000C,32'h0};
        tbl[6]  = '{1'b1,2'd1,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,1'b0,32'h0006_0000,32'h100,      4'd0,32'h0000_0100,32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0000_0100,32'h0};
        tbl[7]  = '{1'b1,2'd3,1'b0,2'd0,1'b1,2'd2,1'b0,1'b0,1'b1,32'h000E_0F00,32'h400,      4'd0,32'h0000_0100,32'hFFFF_FFFF,32'h0000_0404,32'h0000_0400,32'h0};
        tbl[8]  = '{1'b1,2'd0,1'b1,2'd3,1'b0,2'd1,1'b0,1'b1,1'b0,32'h0003_F000,32'h80,       4'd0,32'h0000_0084,32'hDEAD_BEEF,32'hFFFF_FFFF,32'h0000_0080,32'h0};
        tbl[9]  = '{1'b1,2'd2,1'b0,2'd2,1'b0,2'd3,1'b0,1'b1,1'b0,32'h000D_0000,32'h2000_0000,4'd13,32'h2000_0000,32'h2000_0000,32'hFFFF_FFFF,32'h0000_0080,32'h2000_0000};
        tbl[10] = '{1'b0,2'd0,1'b0,2'd0,1'b0,2'd2,1'b0,1'b0,1'b0,32'h000F_0000,32'hFFFF_FFFC,4'd0,32'h0000_0000,32'hFFFF_FFFF,32'hFFFF_FFFF,32'hFFFF_FFFC,32'h2000_0000};
        tbl[11] = '{1'b0,2'd0,1'b0,2'd0,1'b0,2'd1,1'b0,1'b0,1'b0,32'h000F_0000,32'h0,        4'd0,32'h0000_0004,32'hFFFF_FFFF,32'hFFFF_FFFF,32'h0000_0000,32'h2000_0000};

        idle_inputs();
        rst = 1'b0;
        #12;
        chk("reset_pc", pc, 32'h0);
        chk("reset_a", a_bus, 32'h0);
        do_reset();

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            latch = tbl[i].latch; rd_sel = tbl[i].rd_sel; rn_sel = tbl[i].rn_sel;
            rm_sel = tbl[i].rm_sel; rd_mux = tbl[i].rd_mux; pc_mux = tbl[i].pc_mux;
            data_mux = tbl[i].data_mux; gate_b = tbl[i].gate_b; gate_c = tbl[i].gate_c;
            ir = tbl[i].ir; alu = tbl[i].alu; cnt = tbl[i].cnt;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_a", i), a_bus, tbl[i].exp_a);
            chk($sformatf("vec%0d_b", i), b_bus, tbl[i].exp_b);
            chk($sformatf("vec%0d_c", i), c_bus, tbl[i].exp_c);
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("vec%0d_st", i), st, tbl[i].exp_st);
        end

        // Asynchronous reset mid-cycle with both gates high.
        @(negedge clk);
        idle_inputs();
        ir = 32'h0000_3000; rn_sel = 1'b1; rm_sel = 2'd1; gate_b = 1'b1; gate_c = 1'b1;
        #1;
        chk("pre_reset_a", a_bus, 32'hDEAD_BEEF);
        rst = 1'b0;
        #1;
        chk("rst_a", a_bus, 32'h0);
        chk("rst_b_released", b_bus, 32'hFFFF_FFFF);
        chk("rst_c_released", c_bus, 32'hFFFF_FFFF);
        chk("rst_pc", pc, 32'h0);
        chk("rst_st", st, 32'h0);
        latch = 1'b1; pc_mux = 2'd1; alu = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("rst_hold_pc", pc, 32'h0);
        chk("rst_hold_a", a_bus, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // External load data through B_BUS with the bank's B gate low.
        idle_inputs();
        ir = 32'h0000_4000; rn_sel = 1'b1; latch = 1'b1; data_mux = 1'b1;
        b_drv_en = 1'b1; b_drv_val = 32'h7;
        #1;
        chk("load_b_ext", b_bus, 32'h7);
        @(posedge clk);
        #1;
        chk("load_dest", a_bus, 32'h7);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            r = $urandom;
            latch = r[0]; rd_sel = r[2:1]; rn_sel = r[3]; rm_sel = r[5:4];
            rd_mux = (r[8:6] == 3'd0); pc_mux = r[10:9]; data_mux = r[11];
            gate_b = r[12]; gate_c = r[13]; cnt = r[17:14];
            b_drv_en = !r[12] && r[18];
            ir = $urandom;
            alu = $urandom;
            b_drv_val = $urandom;
            #1;
            dsel = '{ir[15:12], ir[19:16], cnt, 4'd14};
            bsel = '{ir[3:0], ir[15:12], cnt, ir[19:16]};
            a_idx = rn_sel ? ir[15:12] : ir[19:16];
            d = dsel[rd_sel];
            e_b = gate_b ? model_read(bsel[rm_sel]) : (b_drv_en ? b_drv_val : 32'hFFFF_FFFF);
            chk("rand_a", a_bus, model_read(a_idx));
            chk("rand_b", b_bus, e_b);
            chk("rand_c", c_bus, gate_c ? model_read(ir[11:8]) : 32'hFFFF_FFFF);
            chk("rand_pc", pc, m[15]);
            chk("rand_st", st, m[13]);
            wd = rd_mux ? m[15] : (data_mux ? e_b : alu);
            nm = m;
            if (pc_mux == 2'd1) nm[15] = m[15] + 32'd4;
            if (pc_mux == 2'd2) nm[15] = alu;
            if (latch) nm[d] = wd;
            @(posedge clk);
            m = nm;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
